// File: rtl/cv32e40x_xif_result_queue.sv
// In-order result queue between the AES coprocessor FU and the XIF result interface.
// Latency: an entry filled and committed by cycle N is presented in cycle N+1 when it is at the head.
// Backpressure: holds the head result stable while result_ready_i is low; alloc stalls when full.
//
// Ports:
//   clk_i, rst_n                     clock, synchronous active-low reset
//   alloc_valid_i/_ready_o/_id_i/_rd_i  allocate one entry per accepted offload
//   fu_valid_i/_ready_o/_data_i      FU results, returned in issue order
//   commit_valid_i/_id_i/_kill_i     commit or kill every live entry with a matching id
//   result_valid_o/_ready_i/_id_o/_rd_o/_data_o/_we_o  head result towards the core
//   count_o                          number of live entries
module cv32e40x_xif_result_queue #(
    parameter int DEPTH       = 4,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic                       alloc_valid_i,
    output logic                       alloc_ready_o,
    input  logic [X_ID_WIDTH-1:0]      alloc_id_i,
    input  logic [4:0]                 alloc_rd_i,
    input  logic                       fu_valid_i,
    output logic                       fu_ready_o,
    input  logic [X_RFW_WIDTH-1:0]     fu_data_i,
    input  logic                       commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]      commit_id_i,
    input  logic                       commit_kill_i,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic [X_ID_WIDTH-1:0]      result_id_o,
    output logic [4:0]                 result_rd_o,
    output logic [X_RFW_WIDTH-1:0]     result_data_o,
    output logic                       result_we_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic                   live;
        logic [X_ID_WIDTH-1:0]  id;
        logic [4:0]             rd;
        logic [X_RFW_WIDTH-1:0] data;
        logic                   filled;
        logic                   committed;
        logic                   killed;
    } entry_t;

    entry_t             entries_q [DEPTH];
    entry_t             entries_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   fill_ptr_q, fill_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   unfilled_q, unfilled_d;

    entry_t head;
    logic   alloc_fire;
    logic   fill_fire;
    logic   pop_fire;
    logic   drop_fire;
    logic   release_fire;
    logic   alloc_cmt_match;

    // Handshake readiness depends only on registered state, so a pop in a
    // full cycle cannot open a slot for an alloc in that same cycle.
    assign head           = entries_q[rd_ptr_q];
    assign alloc_ready_o  = (count_q < DEPTH_C);
    assign fu_ready_o     = (unfilled_q != '0);
    assign result_valid_o = head.live & head.filled & head.committed & ~head.killed;
    assign result_we_o    = result_valid_o;
    assign result_id_o    = head.id;
    assign result_rd_o    = head.rd;
    assign result_data_o  = head.data;
    assign count_o        = count_q;

    assign alloc_fire      = alloc_valid_i & alloc_ready_o;
    assign fill_fire       = fu_valid_i & fu_ready_o;
    assign pop_fire        = result_valid_o & result_ready_i;
    // Killed entries leave the head silently, but only once their FU result
    // has arrived so fill_ptr never points at a freed slot.
    assign drop_fire       = head.live & head.filled & head.killed;
    assign release_fire    = pop_fire | drop_fire;
    assign alloc_cmt_match = commit_valid_i & (commit_id_i == alloc_id_i);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
        end
        wr_ptr_d   = wr_ptr_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (commit_valid_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries_q[i].live && (entries_q[i].id == commit_id_i)) begin
                    if (commit_kill_i) begin
                        // A committed result is architecturally owed; late kills are ignored.
                        if (!entries_q[i].committed) entries_d[i].killed = 1'b1;
                    end else begin
                        entries_d[i].committed = 1'b1;
                    end
                end
            end
        end

        if (fill_fire) begin
            entries_d[fill_ptr_q].data   = fu_data_i;
            entries_d[fill_ptr_q].filled = 1'b1;
            fill_ptr_d                   = fill_ptr_q + 1'b1;
        end

        // The alloc slot is never live, so it cannot collide with the
        // commit, fill or release updates above and below.
        if (alloc_fire) begin
            entries_d[wr_ptr_q].live      = 1'b1;
            entries_d[wr_ptr_q].id        = alloc_id_i;
            entries_d[wr_ptr_q].rd        = alloc_rd_i;
            entries_d[wr_ptr_q].data      = '0;
            entries_d[wr_ptr_q].filled    = 1'b0;
            entries_d[wr_ptr_q].committed = alloc_cmt_match & ~commit_kill_i;
            entries_d[wr_ptr_q].killed    = alloc_cmt_match & commit_kill_i;
            wr_ptr_d                      = wr_ptr_q + 1'b1;
        end

        if (release_fire) begin
            entries_d[rd_ptr_q].live = 1'b0;
            rd_ptr_d                 = rd_ptr_q + 1'b1;
        end

        count_d    = count_q + CNT_W'(alloc_fire) - CNT_W'(release_fire);
        unfilled_d = unfilled_q + CNT_W'(alloc_fire) - CNT_W'(fill_fire);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            unfilled_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            unfilled_q <= unfilled_d;
        end
    end

endmodule

// File: tb/tb_cv32e40x_xif_result_queue.sv
// Self-checking bench for cv32e40x_xif_result_queue.
// Latency: inputs driven on the falling edge, outputs checked on the next falling edge.
// Backpressure: result_ready_i is driven by directed rows, hand sequences and random draws.
module tb_cv32e40x_xif_result_queue;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        alloc_valid_i = 1'b0;
    logic        alloc_ready_o;
    logic [3:0]  alloc_id_i = '0;
    logic [4:0]  alloc_rd_i = '0;
    logic        fu_valid_i = 1'b0;
    logic        fu_ready_o;
    logic [31:0] fu_data_i = '0;
    logic        commit_valid_i = 1'b0;
    logic [3:0]  commit_id_i = '0;
    logic        commit_kill_i = 1'b0;
    logic        result_valid_o;
    logic        result_ready_i = 1'b0;
    logic [3:0]  result_id_o;
    logic [4:0]  result_rd_o;
    logic [31:0] result_data_o;
    logic        result_we_o;
    logic [2:0]  count_o;

    always #5 clk_i = ~clk_i;

    cv32e40x_xif_result_queue #(.DEPTH(DEPTH), .X_ID_WIDTH(4), .X_RFW_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .alloc_id_i(alloc_id_i), .alloc_rd_i(alloc_rd_i),
        .fu_valid_i(fu_valid_i), .fu_ready_o(fu_ready_o), .fu_data_i(fu_data_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_rd_o(result_rd_o), .result_data_o(result_data_o),
        .result_we_o(result_we_o), .count_o(count_o)
    );

    typedef struct {
        bit          av;
        logic [3:0]  aid;
        logic [4:0]  ard;
        bit          fv;
        logic [31:0] fd;
        bit          cv;
        logic [3:0]  cid;
        bit          ck;
        bit          rr;
    } in_t;

    typedef struct {
        in_t         in;
        int          cnt;
        bit          ardy;
        bit          frdy;
        bit          rvld;
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
    } vec_t;

    // Reference model: the queue contents in issue order, head at index 0.
    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          filled;
        bit          committed;
        bit          killed;
    } ment_t;

    ment_t mq[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t r;
        r.av = 0; r.aid = '0; r.ard = '0; r.fv = 0; r.fd = '0;
        r.cv = 0; r.cid = '0; r.ck = 0; r.rr = 0;
        return r;
    endfunction

    function automatic bit m_valid();
        return (mq.size() > 0) && mq[0].filled && mq[0].committed && !mq[0].killed;
    endfunction

    function automatic bit m_fu_ready();
        foreach (mq[i]) if (!mq[i].filled) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input in_t in);
        int    sz;
        bit    pop;
        bit    drop;
        bit    alloc;
        ment_t e;
        if (!rst_n) begin
            mq.delete();
            return;
        end
        sz    = mq.size();
        pop   = m_valid() && in.rr;
        drop  = (sz > 0) && mq[0].filled && mq[0].killed;
        alloc = in.av && (sz < DEPTH);
        if (in.fv) begin
            for (int i = 0; i < sz; i++) begin
                if (!mq[i].filled) begin
                    mq[i].filled = 1;
                    mq[i].data   = in.fd;
                    break;
                end
            end
        end
        if (in.cv) begin
            for (int i = 0; i < sz; i++) begin
                if (mq[i].id == in.cid) begin
                    if (in.ck) begin
                        if (!mq[i].committed) mq[i].killed = 1;
                    end else begin
                        mq[i].committed = 1;
                    end
                end
            end
        end
        if (pop || drop) void'(mq.pop_front());
        if (alloc) begin
            e.id        = in.aid;
            e.rd        = in.ard;
            e.data      = '0;
            e.filled    = 0;
            e.committed = in.cv && (in.cid == in.aid) && !in.ck;
            e.killed    = in.cv && (in.cid == in.aid) && in.ck;
            mq.push_back(e);
        end
    endtask

    task automatic compare_model();
        chk("model_count", 32'(count_o), 32'(mq.size()));
        chk("model_alloc_ready", 32'(alloc_ready_o), 32'(mq.size() < DEPTH));
        chk("model_fu_ready", 32'(fu_ready_o), 32'(m_fu_ready()));
        chk("model_result_valid", 32'(result_valid_o), 32'(m_valid()));
        chk("model_result_we", 32'(result_we_o), 32'(m_valid()));
        if (m_valid()) begin
            chk("model_result_id", 32'(result_id_o), 32'(mq[0].id));
            chk("model_result_rd", 32'(result_rd_o), 32'(mq[0].rd));
            chk("model_result_data", result_data_o, mq[0].data);
        end
    endtask

    // Inputs are applied at a falling edge, take effect at the rising edge,
    // and outputs are checked at the following falling edge.
    task automatic tick(input in_t in);
        alloc_valid_i  = in.av;
        alloc_id_i     = in.aid;
        alloc_rd_i     = in.ard;
        fu_valid_i     = in.fv;
        fu_data_i      = in.fd;
        commit_valid_i = in.cv;
        commit_id_i    = in.cid;
        commit_kill_i  = in.ck;
        result_ready_i = in.rr;
        @(posedge clk_i);
        model_step(in);
        @(negedge clk_i);
        compare_model();
    endtask

    function automatic vec_t row(bit av, logic [3:0] aid, logic [4:0] ard, bit fv, logic [31:0] fd,
                                 bit cv, logic [3:0] cid, bit ck, bit rr,
                                 int cnt, bit ardy, bit frdy, bit rvld,
                                 logic [3:0] id, logic [4:0] rd, logic [31:0] data);
        vec_t v;
        v.in.av = av; v.in.aid = aid; v.in.ard = ard; v.in.fv = fv; v.in.fd = fd;
        v.in.cv = cv; v.in.cid = cid; v.in.ck = ck; v.in.rr = rr;
        v.cnt = cnt; v.ardy = ardy; v.frdy = frdy; v.rvld = rvld;
        v.id = id; v.rd = rd; v.data = data;
        return v;
    endfunction

    initial begin
        vec_t       vecs[14];
        in_t        in;
        logic [3:0] next_id;
        logic [3:0] exp_ids[$];

        // Directed rows: cases 1 (basic), 3 (kill/drop), 4 (commit with alloc).
        //              av aid    ard    fv fd            cv cid   ck rr  cnt ar fr rv id     rd     data
        vecs[0]  = row(1, 4'd3,  5'd5,  0, 32'h0,        0, 4'd0,  0, 0,  1, 1, 1, 0, 4'd0,  5'd0,  32'h0);
        vecs[1]  = row(0, 4'd0,  5'd0,  1, 32'hDEADBEEF, 0, 4'd0,  0, 0,  1, 1, 0, 0, 4'd0,  5'd0,  32'h0);
        vecs[2]  = row(0, 4'd0,  5'd0,  0, 32'h0,        1, 4'd3,  0, 0,  1, 1, 0, 1, 4'd3,  5'd5,  32'hDEADBEEF);
        vecs[3]  = row(0, 4'd0,  5'd0,  0, 32'h0,        0, 4'd0,  0, 1,  0, 1, 0, 0, 4'd0,  5'd0,  32'h0);
        vecs[4]  = row(1, 4'd1,  5'd1,  0, 32'h0,        0, 4'd0,  0, 0,  1, 1, 1, 0, 4'd0,  5'd0,  32'h0);
        vecs[5]  = row(1, 4'd2,  5'd2,  0, 32'h0,        1, 4'd1,  1, 0,  2, 1, 1, 0, 4'd0,  5'd0,  32'h0);
        vecs[6]  = row(0, 4'd0,  5'd0,  0, 32'h0,        1, 4'd2,  0, 0,  2, 1, 1, 0, 4'd0,  5'd0,  32'h0);
        vecs[7]  = row(0, 4'd0,  5'd0,  1, 32'h111,      0, 4'd0,  0, 0,  2, 1, 1, 0, 4'd0,  5'd0,  32'h0);
        vecs[8]  = row(0, 4'd0,  5'd0,  1, 32'h222,      0, 4'd0,  0, 1,  1, 1, 0, 1, 4'd2,  5'd2,  32'h222);
        vecs[9]  = row(0, 4'd0,  5'd0,  0, 32'h0,        0, 4'd0,  0, 1,  0, 1, 0, 0, 4'd0,  5'd0,  32'h0);
        vecs[10] = row(1, 4'd7,  5'd9,  0, 32'h0,        1, 4'd7,  0, 0,  1, 1, 1, 0, 4'd0,  5'd0,  32'h0);
        vecs[11] = row(0, 4'd0,  5'd0,  1, 32'h77,       0, 4'd0,  0, 0,  1, 1, 0, 1, 4'd7,  5'd9,  32'h77);
        vecs[12] = row(0, 4'd0,  5'd0,  0, 32'h0,        0, 4'd0,  0, 1,  0, 1, 0, 0, 4'd0,  5'd0,  32'h0);
        vecs[13] = row(0, 4'd0,  5'd0,  0, 32'h0,        1, 4'd5,  0, 0,  0, 1, 0, 0, 4'd0,  5'd0,  32'h0);

        // Reset state.
        rst_n = 1'b0;
        tick(idle());
        tick(idle());
        chk("reset_count", 32'(count_o), 32'd0);
        chk("reset_alloc_ready", 32'(alloc_ready_o), 32'd1);
        chk("reset_fu_ready", 32'(fu_ready_o), 32'd0);
        chk("reset_result_valid", 32'(result_valid_o), 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 14; k++) begin
            tick(vecs[k].in);
            chk($sformatf("vec%0d_count", k), 32'(count_o), 32'(vecs[k].cnt));
            chk($sformatf("vec%0d_alloc_ready", k), 32'(alloc_ready_o), 32'(vecs[k].ardy));
            chk($sformatf("vec%0d_fu_ready", k), 32'(fu_ready_o), 32'(vecs[k].frdy));
            chk($sformatf("vec%0d_result_valid", k), 32'(result_valid_o), 32'(vecs[k].rvld));
            if (vecs[k].rvld) begin
                chk($sformatf("vec%0d_id", k), 32'(result_id_o), 32'(vecs[k].id));
                chk($sformatf("vec%0d_rd", k), 32'(result_rd_o), 32'(vecs[k].rd));
                chk($sformatf("vec%0d_data", k), result_data_o, vecs[k].data);
            end
        end

        // Full queue, pop frees the slot only in the following cycle, wrap-around order.
        for (int i = 1; i <= 4; i++) begin
            in = idle(); in.av = 1; in.aid = 4'(i); in.ard = 5'(i); in.cv = 1; in.cid = 4'(i);
            tick(in);
        end
        chk("full_count", 32'(count_o), 32'd4);
        chk("full_alloc_ready", 32'(alloc_ready_o), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            in = idle(); in.fv = 1; in.fd = 32'(100 + i);
            if (i == 1) begin in.av = 1; in.aid = 4'd9; in.ard = 5'd9; end
            tick(in);
        end
        chk("full_head_id", 32'(result_id_o), 32'd1);
        in = idle(); in.rr = 1; in.av = 1; in.aid = 4'd5; in.ard = 5'd5; in.cv = 1; in.cid = 4'd5;
        tick(in);
        chk("pop_full_count", 32'(count_o), 32'd3);
        chk("pop_full_alloc_ready", 32'(alloc_ready_o), 32'd1);
        for (int i = 5; i <= 8; i++) begin
            if (i <= 7) chk("wrap_pop_order", 32'(result_id_o), 32'(i - 3));
            in = idle(); in.rr = 1; in.av = 1; in.aid = 4'(i); in.ard = 5'(i); in.cv = 1; in.cid = 4'(i);
            tick(in);
        end
        chk("wrap_count", 32'(count_o), 32'd4);
        exp_ids = '{4'd5, 4'd6, 4'd7, 4'd8};
        for (int c = 0; c < 40 && exp_ids.size() > 0; c++) begin
            if (result_valid_o) begin
                chk("wrap_out_order", 32'(result_id_o), 32'(exp_ids[0]));
                void'(exp_ids.pop_front());
            end
            in = idle(); in.rr = 1; in.fv = 1; in.fd = 32'(200 + c);
            tick(in);
        end
        chk("wrap_all_out", 32'(exp_ids.size()), 32'd0);

        // Head held stable under backpressure; a kill of a committed head is ignored.
        in = idle(); in.av = 1; in.aid = 4'd10; in.ard = 5'd11; in.cv = 1; in.cid = 4'd10;
        tick(in);
        in = idle(); in.fv = 1; in.fd = 32'hCAFEF00D;
        tick(in);
        for (int k = 0; k < 5; k++) begin
            in = idle();
            if (k == 2) begin in.cv = 1; in.cid = 4'd10; in.ck = 1; end
            tick(in);
            chk("hold_valid", 32'(result_valid_o), 32'd1);
            chk("hold_id", 32'(result_id_o), 32'd10);
            chk("hold_rd", 32'(result_rd_o), 32'd11);
            chk("hold_data", result_data_o, 32'hCAFEF00D);
        end
        in = idle(); in.rr = 1;
        tick(in);
        chk("hold_release_count", 32'(count_o), 32'd0);

        // Mid-operation reset with three live entries.
        for (int i = 1; i <= 3; i++) begin
            in = idle(); in.av = 1; in.aid = 4'(i); in.ard = 5'(i); in.fv = (i == 2); in.fd = 32'h55;
            tick(in);
        end
        chk("pre_reset_count", 32'(count_o), 32'd3);
        rst_n = 1'b0;
        tick(idle());
        chk("midrst_count", 32'(count_o), 32'd0);
        chk("midrst_result_valid", 32'(result_valid_o), 32'd0);
        chk("midrst_fu_ready", 32'(fu_ready_o), 32'd0);
        chk("midrst_alloc_ready", 32'(alloc_ready_o), 32'd1);
        rst_n = 1'b1;

        // Random traffic against the reference model.
        next_id = '0;
        for (int c = 0; c < 2000; c++) begin
            in     = idle();
            in.av  = ($urandom_range(0, 2) != 0);
            in.aid = next_id;
            in.ard = 5'($urandom);
            if (in.av && (mq.size() < DEPTH)) next_id = next_id + 4'd1;
            in.fv  = ($urandom_range(0, 1) != 0);
            in.fd  = $urandom;
            in.cv  = ($urandom_range(0, 1) != 0);
            if ((mq.size() > 0) && ($urandom_range(0, 3) != 0))
                in.cid = mq[$urandom_range(0, mq.size() - 1)].id;
            else
                in.cid = 4'($urandom);
            if (in.av && ($urandom_range(0, 5) == 0)) in.cid = in.aid;
            in.ck  = ($urandom_range(0, 3) == 0);
            in.rr  = ($urandom_range(0, 3) != 0);
            tick(in);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
